// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction engine.
// Contents: error codes, FSM state encoding, saturating-add helpers.
package vend_pkg;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_BAD_SEL   = 2'b01;
  localparam logic [1:0] ERR_NO_SUPPLY = 2'b10;
  localparam logic [1:0] ERR_NO_FUNDS  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StCommit,
    StResp
  } state_e;

  // Add two values and clamp the result at max. Operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

  // True when a + b would exceed max, i.e. sat_add clamps.
  function automatic logic sat_hit(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum > {1'b0, max};
  endfunction

endpackage

// File: rtl/vend_txn_engine_if.sv
// Request/response bus of the vending transaction engine.
//  req_*  : purchase request, valid/ready handshake (master -> engine)
//  resp_* : result, valid/ready handshake (engine -> master), with change, units,
//           error code and red light held stable while resp_valid is high.
interface vend_txn_engine_if #(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned QTY_W   = 4,
  parameter int unsigned MONEY_W = 8
);

  logic               req_valid;
  logic               req_ready;
  logic [SEL_W-1:0]   req_prod;
  logic [QTY_W-1:0]   req_qty;
  logic [MONEY_W-1:0] req_money;

  logic               resp_valid;
  logic               resp_ready;
  logic [MONEY_W-1:0] remaining_money;
  logic [QTY_W-1:0]   dispense_qty;
  logic [1:0]         err_code;
  logic               redlight;

  modport master (
    output req_valid, req_prod, req_qty, req_money, resp_ready,
    input  req_ready, resp_valid, remaining_money, dispense_qty, err_code, redlight
  );

  modport slave (
    input  req_valid, req_prod, req_qty, req_money, resp_ready,
    output req_ready, resp_valid, remaining_money, dispense_qty, err_code, redlight
  );

endinterface

// File: rtl/vend_supply_bank.sv
// Per-product supply counters.
//  clk, rst     : clock, asynchronous active-high reset (loads INIT_SUPPLY everywhere)
//  rs_en        : restock strobe, already qualified by admin mode
//  rs_prod      : restock slot (out-of-range index matches nothing and is ignored)
//  rs_amount    : units added, saturating
//  cm_en        : commit of a successful sale
//  cm_prod      : sold slot
//  cm_qty       : units removed (never more than the slot holds)
//  supply_flat  : slot i at [i*SUPPLY_W +: SUPPLY_W]
module vend_supply_bank
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PROD    = 4,
  parameter int unsigned QTY_W       = 4,
  parameter int unsigned SUPPLY_W    = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned INIT_SUPPLY = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rs_en,
  input  logic [SEL_W-1:0]             rs_prod,
  input  logic [SUPPLY_W-1:0]          rs_amount,
  input  logic                         cm_en,
  input  logic [SEL_W-1:0]             cm_prod,
  input  logic [QTY_W-1:0]             cm_qty,
  output logic [NUM_PROD*SUPPLY_W-1:0] supply_flat
);

  localparam logic [31:0] SupMax = 32'((64'd1 << SUPPLY_W) - 64'd1);

  logic [SUPPLY_W-1:0] supply_q [NUM_PROD];
  logic [SUPPLY_W-1:0] supply_d [NUM_PROD];

  // Restock and sale may hit the same slot in one cycle; the sale is subtracted first
  // (it cannot underflow) and the restock added with saturation, giving one net update.
  always_comb begin
    logic [31:0] add;
    logic [31:0] sub;
    for (int i = 0; i < int'(NUM_PROD); i++) begin
      add = (rs_en && rs_prod == SEL_W'(i)) ? 32'(rs_amount) : 32'd0;
      sub = (cm_en && cm_prod == SEL_W'(i)) ? 32'(cm_qty) : 32'd0;
      supply_d[i] = SUPPLY_W'(sat_add(32'(supply_q[i]) - sub, add, SupMax));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_PROD); i++) begin
        supply_q[i] <= SUPPLY_W'(INIT_SUPPLY);
      end
    end else begin
      for (int i = 0; i < int'(NUM_PROD); i++) begin
        supply_q[i] <= supply_d[i];
      end
    end
  end

  always_comb begin
    supply_flat = '0;
    for (int i = 0; i < int'(NUM_PROD); i++) begin
      supply_flat[i*SUPPLY_W +: SUPPLY_W] = supply_q[i];
    end
  end

endmodule

// File: rtl/vend_txn_engine.sv
// Customer-mode vending transaction engine.
//  clk, rst       : clock, asynchronous active-high reset
//  mode           : 1 = customer (accept purchases), 0 = admin (restock allowed)
//  bus            : request/response handshake bus (slave side)
//  price_tbl      : price of slot i at [i*MONEY_W +: MONEY_W], sampled at accept
//  rs_valid/rs_prod/rs_amount : restock strobe, honoured only in admin mode
//  supply_flat    : current supply per slot
//  machine_money  : cash bank, saturating
//  bank_full      : sticky flag, set when a bank add saturated
// Flow: IDLE (accept) -> CALC (cost, error) -> COMMIT (update state) -> RESP (hold until taken).
module vend_txn_engine
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PROD    = 4,
  parameter int unsigned MONEY_W     = 8,
  parameter int unsigned QTY_W       = 4,
  parameter int unsigned SUPPLY_W    = 4,
  parameter int unsigned BANK_W      = 11,
  parameter int unsigned INIT_SUPPLY = 10,
  parameter int unsigned SEL_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  vend_txn_engine_if.slave             bus,
  input  logic [NUM_PROD*MONEY_W-1:0]  price_tbl,
  input  logic                         rs_valid,
  input  logic [SEL_W-1:0]             rs_prod,
  input  logic [SUPPLY_W-1:0]          rs_amount,
  output logic [NUM_PROD*SUPPLY_W-1:0] supply_flat,
  output logic [BANK_W-1:0]            machine_money,
  output logic                         bank_full
);

  localparam int unsigned CostW   = MONEY_W + QTY_W;
  localparam logic [31:0] BankMax = 32'((64'd1 << BANK_W) - 64'd1);

  state_e               state_q, state_d;
  logic                 ready_en_q;
  logic [SEL_W-1:0]     prod_q;
  logic [QTY_W-1:0]     qty_q;
  logic [MONEY_W-1:0]   money_q;
  logic [MONEY_W-1:0]   price_q;
  logic [CostW-1:0]     cost_q, cost_d;
  logic [1:0]           err_q, err_d;
  logic [MONEY_W-1:0]   rem_q;
  logic [QTY_W-1:0]     disp_q;
  logic [1:0]           err_out_q;
  logic                 red_q;
  logic [BANK_W-1:0]    bank_q;
  logic                 full_q;

  logic                 accept;
  logic                 in_commit;
  logic                 commit_ok;
  logic [MONEY_W-1:0]   price_sel;
  logic [SUPPLY_W-1:0]  sup_sel;

  // Ready is held off for the first cycle after reset so nothing is accepted while
  // the rest of the system may still be coming out of reset.
  assign bus.req_ready = (state_q == StIdle) && mode && ready_en_q;
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_commit     = (state_q == StCommit);
  assign commit_ok     = in_commit && (err_q == ERR_OK);

  // Price lookup for the incoming request; out-of-range selects read as zero.
  always_comb begin
    price_sel = '0;
    for (int i = 0; i < int'(NUM_PROD); i++) begin
      if (bus.req_prod == SEL_W'(i)) price_sel = price_tbl[i*MONEY_W +: MONEY_W];
    end
  end

  // Supply of the latched product, read live during CALC.
  always_comb begin
    sup_sel = '0;
    for (int i = 0; i < int'(NUM_PROD); i++) begin
      if (prod_q == SEL_W'(i)) sup_sel = supply_flat[i*SUPPLY_W +: SUPPLY_W];
    end
  end

  // Cost and error classification, highest priority first.
  always_comb begin
    cost_d = CostW'(price_q) * CostW'(qty_q);
    if (32'(prod_q) >= NUM_PROD || qty_q == '0) begin
      err_d = ERR_BAD_SEL;
    end else if (32'(qty_q) > 32'(sup_sel)) begin
      err_d = ERR_NO_SUPPLY;
    end else if (CostW'(money_q) < cost_d) begin
      err_d = ERR_NO_FUNDS;
    end else begin
      err_d = ERR_OK;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StCalc;
      StCalc:   state_d = StCommit;
      StCommit: state_d = StResp;
      StResp:   if (bus.resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ready_en_q <= 1'b0;
      prod_q     <= '0;
      qty_q      <= '0;
      money_q    <= '0;
      price_q    <= '0;
      cost_q     <= '0;
      err_q      <= ERR_OK;
      rem_q      <= '0;
      disp_q     <= '0;
      err_out_q  <= ERR_OK;
      red_q      <= 1'b0;
      bank_q     <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (accept) begin
        prod_q  <= bus.req_prod;
        qty_q   <= bus.req_qty;
        money_q <= bus.req_money;
        price_q <= price_sel;
      end
      if (state_q == StCalc) begin
        cost_q <= cost_d;
        err_q  <= err_d;
      end
      if (in_commit) begin
        // On success cost <= money, so the low bits of cost give the exact change.
        rem_q     <= commit_ok ? money_q - cost_q[MONEY_W-1:0] : money_q;
        disp_q    <= commit_ok ? qty_q : '0;
        err_out_q <= err_q;
        red_q     <= (err_q != ERR_OK);
      end
      if (commit_ok) begin
        bank_q <= BANK_W'(sat_add(32'(bank_q), 32'(cost_q), BankMax));
        if (sat_hit(32'(bank_q), 32'(cost_q), BankMax)) full_q <= 1'b1;
      end
    end
  end

  vend_supply_bank #(
    .NUM_PROD    (NUM_PROD),
    .QTY_W       (QTY_W),
    .SUPPLY_W    (SUPPLY_W),
    .SEL_W       (SEL_W),
    .INIT_SUPPLY (INIT_SUPPLY)
  ) u_supply (
    .clk         (clk),
    .rst         (rst),
    .rs_en       (rs_valid && !mode),
    .rs_prod     (rs_prod),
    .rs_amount   (rs_amount),
    .cm_en       (commit_ok),
    .cm_prod     (prod_q),
    .cm_qty      (qty_q),
    .supply_flat (supply_flat)
  );

  assign bus.resp_valid      = (state_q == StResp);
  assign bus.remaining_money = rem_q;
  assign bus.dispense_qty    = disp_q;
  assign bus.err_code        = err_out_q;
  assign bus.redlight        = red_q;
  assign machine_money       = bank_q;
  assign bank_full           = full_q;

endmodule

// File: tb/tb_vend_txn_engine.sv
module tb_vend_txn_engine;

  localparam int unsigned NUM_PROD    = 4;
  localparam int unsigned MONEY_W     = 8;
  localparam int unsigned QTY_W       = 4;
  localparam int unsigned SUPPLY_W    = 4;
  localparam int unsigned BANK_W      = 11;
  localparam int unsigned INIT_SUPPLY = 10;
  localparam int unsigned SEL_W       = 3;

  logic                         clk;
  logic                         rst;
  logic                         mode;
  logic [NUM_PROD*MONEY_W-1:0]  price_tbl;
  logic                         rs_valid;
  logic [SEL_W-1:0]             rs_prod;
  logic [SUPPLY_W-1:0]          rs_amount;
  logic [NUM_PROD*SUPPLY_W-1:0] supply_flat;
  logic [BANK_W-1:0]            machine_money;
  logic                         bank_full;

  int n_assert = 0;
  int n_fail   = 0;

  vend_txn_engine_if #(.SEL_W(SEL_W), .QTY_W(QTY_W), .MONEY_W(MONEY_W)) bus ();

  vend_txn_engine #(
    .NUM_PROD    (NUM_PROD),
    .MONEY_W     (MONEY_W),
    .QTY_W       (QTY_W),
    .SUPPLY_W    (SUPPLY_W),
    .BANK_W      (BANK_W),
    .INIT_SUPPLY (INIT_SUPPLY),
    .SEL_W       (SEL_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .bus           (bus),
    .price_tbl     (price_tbl),
    .rs_valid      (rs_valid),
    .rs_prod       (rs_prod),
    .rs_amount     (rs_amount),
    .supply_flat   (supply_flat),
    .machine_money (machine_money),
    .bank_full     (bank_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and return just after the accepting edge.
  task automatic start_req(input logic [SEL_W-1:0] prod, input logic [QTY_W-1:0] qty,
                           input logic [MONEY_W-1:0] money);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_prod  = prod;
    bus.req_qty   = qty;
    bus.req_money = money;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Wait (bounded) for resp_valid; the response must appear on the third cycle.
  task automatic wait_resp();
    int n;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid) break;
    end
    chk("resp_latency", 32'(n), 32'd3);
  endtask

  task automatic consume();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic [MONEY_W-1:0] rem,
                          input logic [QTY_W-1:0] disp, input logic [1:0] err);
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_change"}, 32'(bus.remaining_money), 32'(rem));
    chk({tag, "_disp"}, 32'(bus.dispense_qty), 32'(disp));
    chk({tag, "_err"}, 32'(bus.err_code), 32'(err));
    chk({tag, "_red"}, 32'(bus.redlight), 32'(err != 2'b00));
  endtask

  initial begin
    rst            = 1'b1;
    mode           = 1'b1;
    rs_valid       = 1'b0;
    rs_prod        = '0;
    rs_amount      = '0;
    bus.req_valid  = 1'b0;
    bus.req_prod   = '0;
    bus.req_qty    = '0;
    bus.req_money  = '0;
    bus.resp_ready = 1'b0;
    price_tbl      = {8'd3, 8'd1, 8'd7, 8'd9};

    // Reset state
    #12;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_change", 32'(bus.remaining_money), 32'd0);
    chk("rst_disp", 32'(bus.dispense_qty), 32'd0);
    chk("rst_err", 32'(bus.err_code), 32'd0);
    chk("rst_red", 32'(bus.redlight), 32'd0);
    chk("rst_supply", 32'(supply_flat), 32'h0000_AAAA);
    chk("rst_bank", 32'(machine_money), 32'd0);
    chk("rst_full", 32'(bank_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_before_clk", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 chk("ready_after_clk", 32'(bus.req_ready), 32'd1);

    // Basic purchase: 2 x 7 from 20
    start_req(3'd1, 4'd2, 8'd20);
    wait_resp();
    chk_resp("buy1", 8'd6, 4'd2, 2'b00);
    chk("buy1_supply", 32'(supply_flat), 32'h0000_AA8A);
    chk("buy1_bank", 32'(machine_money), 32'd14);
    // Response held while not consumed
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_change", 32'(bus.remaining_money), 32'd6);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    consume();
    chk("after_consume_valid", 32'(bus.resp_valid), 32'd0);
    chk("after_consume_ready", 32'(bus.req_ready), 32'd1);

    // Not enough supply
    start_req(3'd2, 4'd11, 8'd255);
    wait_resp();
    chk_resp("nosup", 8'd255, 4'd0, 2'b10);
    chk("nosup_supply", 32'(supply_flat), 32'h0000_AA8A);
    chk("nosup_bank", 32'(machine_money), 32'd14);
    consume();

    // Not enough money: 3 x 9 = 27 > 26
    start_req(3'd0, 4'd3, 8'd26);
    wait_resp();
    chk_resp("nofunds", 8'd26, 4'd0, 2'b11);
    consume();

    // Zero quantity
    start_req(3'd0, 4'd0, 8'd50);
    wait_resp();
    chk_resp("qty0", 8'd50, 4'd0, 2'b01);
    consume();

    // Product index out of range
    start_req(3'd5, 4'd1, 8'd50);
    wait_resp();
    chk_resp("badprod", 8'd50, 4'd0, 2'b01);
    chk("badprod_bank", 32'(machine_money), 32'd14);
    consume();

    // Exact money: 2 x 3 = 6
    start_req(3'd3, 4'd2, 8'd6);
    wait_resp();
    chk_resp("exact", 8'd0, 4'd2, 2'b00);
    chk("exact_supply", 32'(supply_flat), 32'h0000_8A8A);
    chk("exact_bank", 32'(machine_money), 32'd20);
    consume();

    // Buy the whole slot: 10 x 1
    start_req(3'd2, 4'd10, 8'd10);
    wait_resp();
    chk_resp("empty", 8'd0, 4'd10, 2'b00);
    chk("empty_supply", 32'(supply_flat), 32'h0000_808A);
    chk("empty_bank", 32'(machine_money), 32'd30);
    consume();

    // Admin restock
    @(negedge clk);
    mode = 1'b0;
    rs_valid = 1'b1; rs_prod = 3'd3; rs_amount = 4'd9;
    @(negedge clk);
    chk("admin_ready", 32'(bus.req_ready), 32'd0);
    chk("rs_sat", 32'(supply_flat), 32'h0000_F08A);
    rs_prod = 3'd2; rs_amount = 4'd4;
    @(negedge clk);
    chk("rs_add", 32'(supply_flat), 32'h0000_F48A);
    rs_prod = 3'd5; rs_amount = 4'd1;
    @(negedge clk);
    chk("rs_badprod", 32'(supply_flat), 32'h0000_F48A);
    mode = 1'b1; rs_prod = 3'd1; rs_amount = 4'd3;
    @(negedge clk);
    chk("rs_custmode", 32'(supply_flat), 32'h0000_F48A);
    rs_valid = 1'b0;

    // Mode drops mid-transaction; restock lands on the same slot as the commit
    start_req(3'd1, 4'd2, 8'd14);
    @(negedge clk);
    @(negedge clk);
    mode = 1'b0;
    rs_valid = 1'b1; rs_prod = 3'd1; rs_amount = 4'd5;
    @(negedge clk);
    rs_valid = 1'b0;
    chk_resp("mixed", 8'd0, 4'd2, 2'b00);
    chk("mixed_supply", 32'(supply_flat), 32'h0000_F4BA);
    chk("mixed_bank", 32'(machine_money), 32'd44);
    mode = 1'b1;
    consume();

    // Fill the bank with 255-unit sales
    price_tbl[7:0] = 8'd255;
    for (int i = 0; i < 7; i++) begin
      start_req(3'd0, 4'd1, 8'd255);
      wait_resp();
      consume();
    end
    chk("bank_1829", 32'(machine_money), 32'd1829);
    chk("bank_not_full", 32'(bank_full), 32'd0);
    start_req(3'd0, 4'd1, 8'd255);
    wait_resp();
    chk_resp("sat", 8'd0, 4'd1, 2'b00);
    chk("bank_sat", 32'(machine_money), 32'd2047);
    chk("bank_full", 32'(bank_full), 32'd1);
    chk("sat_supply", 32'(supply_flat), 32'h0000_F4B2);
    consume();

    // Asynchronous reset while in CALC
    start_req(3'd0, 4'd1, 8'd255);
    #2 rst = 1'b1;
    #1;
    chk("arst_bank", 32'(machine_money), 32'd0);
    chk("arst_full", 32'(bank_full), 32'd0);
    chk("arst_supply", 32'(supply_flat), 32'h0000_AAAA);
    chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("arst_ready_after", 32'(bus.req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("arst_no_resp", 32'(bus.resp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
